sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_arb_rr.sv | 20 ++
 rtl/sram_arb.sv | 134 +++++++++++++
 tb/tb_sram_arb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and FSM encoding for the two-port SRAM arbiter.
package sram_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: one-hot winner from the request pair and the
// index of the port granted last time.
module sram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // A sole requester wins; on a tie the port not granted last wins.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arb.sv
// Two-port arbiter in front of a single SRAM controller. Each transaction is
// IDLE (grant) -> ACC (N controller cycles) -> DONE (one-cycle ack).
module sram_arb
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              ctrl_en,
  output logic              ctrl_write,
  output logic              ctrl_read,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic [DATA_W-1:0] ctrl_rdata
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          win;
  logic [CNT_W-1:0]    cnt_end;

  sram_arb_rr u_rr (
    .req  ({req1, req0}),
    .last (last_q),
    .win  (win)
  );

  // Final ACC count depends on the registered operation type.
  assign cnt_end = we_q ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);

  // State register and transaction latches; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, count in ACC, ack in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACC;
          cnt_d   = '0;
          gnt_d   = win;
          last_d  = win[1];
          we_d    = win[1] ? we1    : we0;
          addr_d  = win[1] ? addr1  : addr0;
          wdata_d = win[1] ? wdata1 : wdata0;
        end
      end
      ACC: begin
        if (cnt_q == cnt_end) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = ctrl_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);
  assign ack0       = (state_q == DONE) && gnt_q[0];
  assign ack1       = (state_q == DONE) && gnt_q[1];
  assign rdata      = rdata_q;
  assign ctrl_en    = (state_q == ACC);
  assign ctrl_write = (state_q == ACC) && we_q;
  assign ctrl_read  = (state_q == ACC) && !we_q;
  assign ctrl_addr  = addr_q;
  assign ctrl_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a transaction-level reference model.
module tb_sram_arb;

  localparam int AW   = 19;
  localparam int DW   = 16;
  localparam int N_WR = 2;
  localparam int N_RD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, ctrl_en, ctrl_write, ctrl_read;
  logic [DW-1:0] rdata, ctrl_wdata;
  logic [DW-1:0] ctrl_rdata = '0;
  logic [AW-1:0] ctrl_addr;
  logic [1:0]    gnt;

  int n_vec = 0;
  int n_err = 0;

  sram_arb #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(N_WR), .RD_CYCLES(N_RD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .gnt(gnt), .busy(busy),
    .ctrl_en(ctrl_en), .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies the cycles after its grant; cycles
  // 1..N are the access, cycle N+1 is the ack, then the arbiter is free again.
  logic          m_act;
  int            m_t;
  int            m_owner;
  logic          m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic int pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  function automatic int op_len(input logic we);
    return we ? N_WR : N_RD;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_t <= 0; m_owner <= 0; m_last <= 1'b1;
      m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (!m_act) begin
      if (req0 || req1) begin
        m_act   <= 1'b1;
        m_t     <= 1;
        m_owner <= pick(req0, req1, m_last);
        m_last  <= (pick(req0, req1, m_last) == 1);
        m_we    <= (pick(req0, req1, m_last) == 1) ? we1 : we0;
        m_addr  <= (pick(req0, req1, m_last) == 1) ? addr1 : addr0;
        m_wdata <= (pick(req0, req1, m_last) == 1) ? wdata1 : wdata0;
      end
    end else begin
      if (m_t == op_len(m_we) + 1) m_act <= 1'b0;
      else m_t <= m_t + 1;
      if (m_t == op_len(m_we) && !m_we) m_rdata <= ctrl_rdata;
    end
  end

  // Every-cycle compare of all outputs against the model, plus invariants.
  always @(negedge clk) begin
    logic in_acc, in_done;
    in_acc  = m_act && (m_t <= op_len(m_we));
    in_done = m_act && (m_t == op_len(m_we) + 1);
    chk("gnt",        {30'd0, gnt}, m_act ? (m_owner == 1 ? 32'd2 : 32'd1) : 32'd0);
    chk("busy",       {31'd0, busy},       {31'd0, m_act});
    chk("ack0",       {31'd0, ack0},       {31'd0, in_done && m_owner == 0});
    chk("ack1",       {31'd0, ack1},       {31'd0, in_done && m_owner == 1});
    chk("ctrl_en",    {31'd0, ctrl_en},    {31'd0, in_acc});
    chk("ctrl_write", {31'd0, ctrl_write}, {31'd0, in_acc && m_we});
    chk("ctrl_read",  {31'd0, ctrl_read},  {31'd0, in_acc && !m_we});
    chk("ctrl_addr",  {13'd0, ctrl_addr},  {13'd0, m_addr});
    chk("ctrl_wdata", {16'd0, ctrl_wdata}, {16'd0, m_wdata});
    chk("rdata",      {16'd0, rdata},      {16'd0, m_rdata});
    chk("wr_rd_excl", {31'd0, ctrl_write && ctrl_read}, 32'd0);
    chk("ack_excl",   {31'd0, ack0 && ack1}, 32'd0);
    chk("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Issue one request at a negedge; report ack cycle, access-cycle counts and
  // rdata seen during ack. Drops the request during its ack cycle.
  task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int ack_at,
                        output int wr_cnt, output int rd_cnt,
                        output logic [DW-1:0] rd_at_ack, output logic [1:0] gnt1);
    ack_at = -1; wr_cnt = 0; rd_cnt = 0; rd_at_ack = '0; gnt1 = 2'b00;
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) gnt1 = gnt;
      if (ctrl_write) wr_cnt++;
      if (ctrl_read) rd_cnt++;
      if ((p == 0) ? ack0 : ack1) begin
        ack_at = k; rd_at_ack = rdata;
        set_port(p, 1'b0, w, a, d);
        break;
      end
    end
    if (ack_at < 0) begin
      chk("txn_timeout", 32'd0, 32'd1);
      set_port(p, 1'b0, w, a, d);
    end
    $display("txn port%0d we=%0d addr=%h ack@%0d wr=%0d rd=%0d rdata=%h",
             p, w, a, ack_at, wr_cnt, rd_cnt, rd_at_ack);
  endtask

  initial begin
    int ack_at, wrc, rdc, k, nack;
    logic [DW-1:0] rd;
    logic [1:0] g1;
    int order[4];
    int when[4];

    repeat (3) @(negedge clk);
    chk("rst_gnt",   {30'd0, gnt},  32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    rst = 1'b0;

    // Single write from port 0.
    do_txn(0, 1'b1, 19'h00010, 16'hA5A5, ack_at, wrc, rdc, rd, g1);
    chk("wr_ack_lat", ack_at, 32'd3);
    chk("wr_cycles",  wrc,    32'd2);
    chk("wr_gnt",     {30'd0, g1}, 32'd1);

    // Single read from port 1, then a write that must not disturb rdata.
    ctrl_rdata = 16'h1234;
    do_txn(1, 1'b0, 19'h7FFFF, 16'h0000, ack_at, wrc, rdc, rd, g1);
    chk("rd_ack_lat", ack_at, 32'd3);
    chk("rd_cycles",  rdc,    32'd2);
    chk("rd_data",    {16'd0, rd}, 32'h1234);
    chk("rd_gnt",     {30'd0, g1}, 32'd2);
    ctrl_rdata = 16'hFFFF;
    do_txn(1, 1'b1, 19'h00020, 16'h5A5A, ack_at, wrc, rdc, rd, g1);
    chk("wr_keeps_rdata", {16'd0, rd}, 32'h1234);

    // Both ports hold reads for four transactions.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 19'h00100, 16'h0);
    set_port(1, 1'b1, 1'b0, 19'h00200, 16'h0);
    nack = 0;
    for (k = 1; k <= 40 && nack < 4; k++) begin
      ctrl_rdata = 16'(16'h4000 + k);
      @(negedge clk);
      if (ack0 || ack1) begin
        order[nack] = ack1 ? 1 : 0;
        when[nack]  = k;
        $display("tie ack port%0d at cycle %0d rdata=%h", order[nack], k, rdata);
        nack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_count", nack, 32'd4);
    if (nack == 4) begin
      chk("tie_order0", order[0], 32'd0);
      chk("tie_order1", order[1], 32'd1);
      chk("tie_order2", order[2], 32'd0);
      chk("tie_order3", order[3], 32'd1);
      chk("tie_space1", when[1] - when[0], 32'd4);
      chk("tie_space2", when[2] - when[1], 32'd4);
      chk("tie_space3", when[3] - when[2], 32'd4);
    end

    // Port 0 address changes mid-access; port 1 raised mid-access goes next.
    @(negedge clk);
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 19'h00100, 16'h0);
    ack_at = -1;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr0 = 19'h002AA;
        set_port(1, 1'b1, 1'b1, 19'h00055, 16'hBEEF);
      end
      if (k == 2) chk("midacc_addr", {13'd0, ctrl_addr}, 32'h00100);
      if (ack0) req0 = 1'b0;
      if (ack1) begin ack_at = k; req1 = 1'b0; break; end
    end
    $display("midacc port1 ack at cycle %0d", ack_at);
    chk("midacc_p1_ack", ack_at, 32'd7);

    // Reset during the second access cycle of a write.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 19'h00333, 16'hC0DE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt",   {30'd0, gnt}, 32'd0);
    chk("rst_mid_busy",  {31'd0, busy}, 32'd0);
    chk("rst_mid_en",    {29'd0, ctrl_en, ctrl_write, ctrl_read}, 32'd0);
    chk("rst_mid_addr",  {13'd0, ctrl_addr}, 32'd0);
    chk("rst_mid_wdata", {16'd0, ctrl_wdata}, 32'd0);
    chk("rst_mid_rdata", {16'd0, rdata}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ack", {30'd0, ack1, ack0}, 32'd0);
    end
    rst = 1'b0;
    ack_at = -1;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0) begin ack_at = k; req0 = 1'b0; break; end
    end
    $display("post-reset ack0 at cycle %0d", ack_at);
    chk("rst_fresh_lat", ack_at, 32'd3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
